collision_scanner: RTL and testbench
====================================

// Module: collision_scanner
// PURPOSE
// - Parametrised, time-multiplexed frog/car collision detector; successor to the fixed six-car checker.
// - On each frame-start pulse, snapshots the frog position and tests each enabled car in turn, one car per clock.
//   Uses full rectangle overlap with configurable sprite sizes and per-car lane Y.
// - Keeps a sticky hit flag and the index of the first car hit; the game FSM reads both and clears them.
// PARAMETERS
// - NUM_CARS   8    number of cars scanned (1..16)
// - X_W        10   X coordinate width in bits
// - Y_W        9    Y coordinate width in bits
// - FROG_W     32   frog width in pixels
// - FROG_H     32   frog height in pixels
// - CAR_W      32   car width in pixels
// - CAR_H      32   car height in pixels
// - SCREEN_W   640  visible width in pixels; used only with COLLISION_WRAP_EN
// PORTS
// - i_Clk            in   1               system clock
// - i_Rst_L          in   1               asynchronous, active-low reset
// - i_Frame_Start    in   1               one-cycle pulse that starts a scan
// - i_Clear          in   1               clears o_Has_Collided and o_Hit_Idx
// - i_Frog_X         in   X_W             frog top-left X
// - i_Frog_Y         in   Y_W             frog top-left Y
// - i_Car_X          in   NUM_CARS*X_W    packed car top-left X; car k is at [k*X_W +: X_W]
// - i_Car_Y          in   NUM_CARS*Y_W    packed car lane Y; car k is at [k*Y_W +: Y_W]
// - i_Car_En         in   NUM_CARS        per-car enable; 0 means the car is skipped
// - o_Busy           out  1               high while a scan is in progress
// - o_Scan_Done      out  1               one-cycle pulse when a scan completes
// - o_Has_Collided   out  1               sticky hit flag
// - o_Hit_Idx        out  $clog2(NUM_CARS) (min 1)  index of the first car hit
// BEHAVIOUR
// - Reset (i_Rst_L=0, asynchronous): state=IDLE, index=0.
//   All outputs are 0 at reset: o_Busy, o_Scan_Done, o_Has_Collided, o_Hit_Idx.
// - FSM IDLE:
//   - On i_Frame_Start: latch i_Frog_X/Y into a snapshot, index<=0, go to SCAN.
// - FSM SCAN:
//   - Each cycle, test car[index] against the snapshot.
//   - If index==NUM_CARS-1, go to DONE; else index<=index+1.
// - FSM DONE:
//   - Assert o_Scan_Done for one cycle, then go to IDLE.
// - Timing:
//   - Pulse at cycle T gives o_Scan_Done at cycle T+NUM_CARS+1.
//   - o_Busy is high from T+1 through T+NUM_CARS+1 inclusive.
// - Car X/Y and enables are sampled live during SCAN; only the frog position is snapshotted.
// - i_Frame_Start while o_Busy=1 is ignored. There is no restart or queueing.
// - Hit test, with all sums evaluated at X_W+1 / Y_W+1 bits so nothing overflows:
//   - fx < cx+CAR_W and cx < fx+FROG_W, and
//   - fy < cy+CAR_H and cy < fy+FROG_H.
//   - Edge contact is not a hit (the comparisons are strict).
// - Disabled cars (i_Car_En[k]=0) never hit.
// - On a hit with o_Has_Collided=0: set o_Has_Collided=1 and o_Hit_Idx<=index.
//   Later hits do not change o_Hit_Idx until cleared.
// - Flag and index persist across scans until i_Clear.
// - i_Clear in the same cycle as a hit: the hit wins. The flag stays 1 and o_Hit_Idx takes the new index.
// - i_Clear during SCAN is legal and does not disturb the scan.
// - Reset asserted mid-scan aborts immediately. No o_Scan_Done is generated.
// CONFIGURATION
// - COLLISION_WRAP_EN defined:
//   - A car with cx > SCREEN_W-CAR_W is also tested at cx-SCREEN_W, i.e. its wrapped left part.
//   - The wrapped test uses signed X_W+2 arithmetic. The result is the OR of both tests.
//   - No extra latency.
// - COLLISION_WRAP_EN undefined:
//   - Only the unwrapped test is done.
//   - SCREEN_W is unused and must not generate logic.
// TESTING
// 1. Reset: drive i_Rst_L=0 mid-scan -> all outputs 0 immediately; the next pulse starts a clean scan.
// 2. Frog (100,128), car3 at (90,128), all cars enabled, pulse ->
//    o_Has_Collided=1 and o_Hit_Idx=3 by the o_Scan_Done pulse at T+9 (NUM_CARS=8).
// 3. Frog (100,128), car0 at (132,128), exact edge contact -> no hit.
//    Same setup with car0 at (131,128) -> hit, o_Hit_Idx=0.
// 4. Cars 2 and 5 both overlap the frog -> o_Hit_Idx=2. Then i_Clear plus a new scan with only car5 enabled -> o_Hit_Idx=5.
// 5. Second i_Frame_Start 3 cycles into a scan -> ignored; exactly one o_Scan_Done pulse.
//    Then i_Clear in the same cycle as a hit -> flag stays 1.
// 6. With COLLISION_WRAP_EN: car at X=620, frog at X=4 (SCREEN_W=640) -> hit.
//    Without the macro -> no hit.

Source files
------------

// File: rtl/collision_scanner_if.sv
// Bus between the game FSM and the collision scanner: frame/clear controls,
// frog and packed car positions in; scan status and hit report out.
interface collision_scanner_if #(
    parameter int unsigned NUM_CARS = 8,
    parameter int unsigned X_W      = 10,
    parameter int unsigned Y_W      = 9
);
    localparam int unsigned HIT_W = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1;

    logic                    i_Frame_Start;
    logic                    i_Clear;
    logic [X_W-1:0]          i_Frog_X;
    logic [Y_W-1:0]          i_Frog_Y;
    logic [NUM_CARS*X_W-1:0] i_Car_X;
    logic [NUM_CARS*Y_W-1:0] i_Car_Y;
    logic [NUM_CARS-1:0]     i_Car_En;
    logic                    o_Busy;
    logic                    o_Scan_Done;
    logic                    o_Has_Collided;
    logic [HIT_W-1:0]        o_Hit_Idx;

    modport master (
        output i_Frame_Start, i_Clear, i_Frog_X, i_Frog_Y, i_Car_X, i_Car_Y, i_Car_En,
        input  o_Busy, o_Scan_Done, o_Has_Collided, o_Hit_Idx
    );

    modport slave (
        input  i_Frame_Start, i_Clear, i_Frog_X, i_Frog_Y, i_Car_X, i_Car_Y, i_Car_En,
        output o_Busy, o_Scan_Done, o_Has_Collided, o_Hit_Idx
    );
endinterface

// File: rtl/collision_scanner.sv
// Time-multiplexed frog/car rectangle-overlap scanner, one car per clock.
// Optional horizontal wrap-around test enabled by defining COLLISION_WRAP_EN.
module collision_scanner #(
    parameter int unsigned NUM_CARS = 8,
    parameter int unsigned X_W      = 10,
    parameter int unsigned Y_W      = 9,
    parameter int unsigned FROG_W   = 32,
    parameter int unsigned FROG_H   = 32,
    parameter int unsigned CAR_W    = 32,
    parameter int unsigned CAR_H    = 32,
    parameter int unsigned SCREEN_W = 640
) (
    input  logic               i_Clk,
    input  logic               i_Rst_L,
    collision_scanner_if.slave bus
);
    localparam int unsigned IDX_W = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1;
    localparam int unsigned XS_W  = X_W + 1;
    localparam int unsigned YS_W  = Y_W + 1;

    // Elaboration-time sanity checks on the configuration
    if (NUM_CARS < 1 || NUM_CARS > 16) begin : g_bad_num_cars
        $error("collision_scanner: NUM_CARS must be 1..16");
    end
    if (SCREEN_W < CAR_W) begin : g_bad_screen
        $error("collision_scanner: SCREEN_W must be at least CAR_W");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [X_W-1:0]   frog_x_q, frog_x_d;
    logic [Y_W-1:0]   frog_y_q, frog_y_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             hit_flag_q, hit_flag_d;
    logic [IDX_W-1:0] hit_idx_q, hit_idx_d;

    logic [X_W-1:0]   car_x_c;
    logic [Y_W-1:0]   car_y_c;
    logic             car_en_c;
    logic             hit_x_c;
    logic             hit_xw_c;
    logic             hit_y_c;
    logic             hit_c;

    // Select the car under test; constant slices keep the mux simple
    always_comb begin
        car_x_c  = '0;
        car_y_c  = '0;
        car_en_c = 1'b0;
        for (int k = 0; k < NUM_CARS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                car_x_c  = bus.i_Car_X[k*X_W +: X_W];
                car_y_c  = bus.i_Car_Y[k*Y_W +: Y_W];
                car_en_c = bus.i_Car_En[k];
            end
        end
    end

    // Strict rectangle overlap; one extra bit so the sums never wrap
    always_comb begin
        hit_x_c = ({1'b0, frog_x_q} < ({1'b0, car_x_c} + XS_W'(CAR_W))) &&
                  ({1'b0, car_x_c} < ({1'b0, frog_x_q} + XS_W'(FROG_W)));
        hit_y_c = ({1'b0, frog_y_q} < ({1'b0, car_y_c} + YS_W'(CAR_H))) &&
                  ({1'b0, car_y_c} < ({1'b0, frog_y_q} + YS_W'(FROG_H)));
    end

`ifdef COLLISION_WRAP_EN
    localparam int unsigned XW_W = X_W + 2;

    logic signed [XW_W-1:0] wrap_x_c;
    logic signed [XW_W-1:0] frog_xs_c;
    logic                   wrap_need_c;

    // A car hanging off the right edge re-enters on the left at cx-SCREEN_W
    always_comb begin
        wrap_x_c    = $signed({2'b00, car_x_c}) - $signed(XW_W'(SCREEN_W));
        frog_xs_c   = $signed({2'b00, frog_x_q});
        wrap_need_c = ({1'b0, car_x_c} > XS_W'(SCREEN_W - CAR_W));
        hit_xw_c    = wrap_need_c &&
                      (frog_xs_c < (wrap_x_c + $signed(XW_W'(CAR_W)))) &&
                      (wrap_x_c < (frog_xs_c + $signed(XW_W'(FROG_W))));
    end
`else
    assign hit_xw_c = 1'b0;
`endif

    assign hit_c = (state_q == S_SCAN) && car_en_c && (hit_x_c || hit_xw_c) && hit_y_c;

    // Next-state, scan index, frog snapshot and sticky hit report
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        frog_x_d   = frog_x_q;
        frog_y_d   = frog_y_q;
        hit_flag_d = hit_flag_q;
        hit_idx_d  = hit_idx_q;

        case (state_q)
            S_IDLE: begin
                if (bus.i_Frame_Start) begin
                    frog_x_d = bus.i_Frog_X;
                    frog_y_d = bus.i_Frog_Y;
                    idx_d    = '0;
                    state_d  = S_SCAN;
                end
            end
            S_SCAN: begin
                if (idx_q == IDX_W'(NUM_CARS - 1)) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (bus.i_Clear) begin
            hit_flag_d = 1'b0;
            hit_idx_d  = '0;
        end
        // A hit in the same cycle as a clear counts as a fresh first hit
        if (hit_c && (!hit_flag_q || bus.i_Clear)) begin
            hit_flag_d = 1'b1;
            hit_idx_d  = idx_q;
        end

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            frog_x_q   <= '0;
            frog_y_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hit_flag_q <= 1'b0;
            hit_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            frog_x_q   <= frog_x_d;
            frog_y_q   <= frog_y_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            hit_flag_q <= hit_flag_d;
            hit_idx_q  <= hit_idx_d;
        end
    end

    assign bus.o_Busy         = busy_q;
    assign bus.o_Scan_Done    = done_q;
    assign bus.o_Has_Collided = hit_flag_q;
    assign bus.o_Hit_Idx      = hit_idx_q;

endmodule

// File: tb/tb_collision_scanner.sv
// Directed, table-driven bench for collision_scanner (NUM_CARS=8, 640-wide screen).
module tb_collision_scanner;
    localparam int unsigned NUM_CARS = 8;
    localparam int unsigned X_W      = 10;
    localparam int unsigned Y_W      = 9;
    localparam int          LAT      = NUM_CARS + 1;
`ifdef COLLISION_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic clk;
    logic rst_n;

    collision_scanner_if #(.NUM_CARS(NUM_CARS), .X_W(X_W), .Y_W(Y_W)) bus ();

    collision_scanner #(
        .NUM_CARS(NUM_CARS), .X_W(X_W), .Y_W(Y_W),
        .FROG_W(32), .FROG_H(32), .CAR_W(32), .CAR_H(32), .SCREEN_W(640)
    ) dut (
        .i_Clk  (clk),
        .i_Rst_L(rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int             fx;
        int             fy;
        int             na;
        int             ax;
        int             ay;
        int             nb;
        int             bx;
        int             by;
        logic [NUM_CARS-1:0] en;
        bit             clr;
        bit             exp_hit;
        int             exp_idx;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs[NVEC];

    int n_chk = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Park every car far from the frog, then place up to two cars of interest
    task automatic load(input vec_t v);
        for (int k = 0; k < NUM_CARS; k++) begin
            bus.i_Car_X[k*X_W +: X_W] = X_W'(500);
            bus.i_Car_Y[k*Y_W +: Y_W] = Y_W'(400);
        end
        if (v.na >= 0) begin
            bus.i_Car_X[v.na*X_W +: X_W] = X_W'(v.ax);
            bus.i_Car_Y[v.na*Y_W +: Y_W] = Y_W'(v.ay);
        end
        if (v.nb >= 0) begin
            bus.i_Car_X[v.nb*X_W +: X_W] = X_W'(v.bx);
            bus.i_Car_Y[v.nb*Y_W +: Y_W] = Y_W'(v.by);
        end
        bus.i_Car_En = v.en;
        bus.i_Frog_X = X_W'(v.fx);
        bus.i_Frog_Y = Y_W'(v.fy);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        bus.i_Clear = 1'b1;
        @(negedge clk);
        bus.i_Clear = 1'b0;
    endtask

    // Pulse frame start, return cycles from the pulse to o_Scan_Done (bounded)
    task automatic run_scan(output int lat);
        @(negedge clk);
        bus.i_Frame_Start = 1'b1;
        @(negedge clk);
        bus.i_Frame_Start = 1'b0;
        lat = 1;
        while (!bus.o_Scan_Done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int   lat;
        int   ndone;
        int   first_done;
        vec_t v;

        vecs[0]  = '{100, 128, 3,  90, 128, -1,   0,   0, 8'hFF, 1'b1, 1'b1, 3};
        vecs[1]  = '{100, 128, 0, 132, 128, -1,   0,   0, 8'hFF, 1'b1, 1'b0, 0};
        vecs[2]  = '{100, 128, 0, 131, 128, -1,   0,   0, 8'hFF, 1'b1, 1'b1, 0};
        vecs[3]  = '{100, 128, 2, 110, 140,  5,  95, 110, 8'hFF, 1'b1, 1'b1, 2};
        vecs[4]  = '{100, 128, 5,  95, 110, -1,   0,   0, 8'h20, 1'b1, 1'b1, 5};
        vecs[5]  = '{100, 128, 1, 100, 128, -1,   0,   0, 8'hFF, 1'b0, 1'b1, 5};
        vecs[6]  = '{100, 128, 4, 100, 128, -1,   0,   0, 8'hEF, 1'b1, 1'b0, 0};
        vecs[7]  = '{100, 128, 6, 100, 160, -1,   0,   0, 8'hFF, 1'b1, 1'b0, 0};
        vecs[8]  = '{100, 128, 6, 100, 159, -1,   0,   0, 8'hFF, 1'b1, 1'b1, 6};
        vecs[9]  = '{100, 128, 7,  69,  96, -1,   0,   0, 8'hFF, 1'b1, 1'b0, 0};
        vecs[10] = '{100, 128, 7,  69,  97, -1,   0,   0, 8'hFF, 1'b1, 1'b1, 7};
        vecs[11] = '{100, 128, 7,  68,  97, -1,   0,   0, 8'hFF, 1'b1, 1'b0, 0};
        vecs[12] = '{100, 128, -1,  0,   0, -1,   0,   0, 8'hFF, 1'b0, 1'b0, 0};
        vecs[13] = '{  4, 128, 2, 620, 128, -1,   0,   0, 8'hFF, 1'b1, WRAP, WRAP ? 2 : 0};

        rst_n             = 1'b0;
        bus.i_Frame_Start = 1'b0;
        bus.i_Clear       = 1'b0;
        bus.i_Frog_X      = '0;
        bus.i_Frog_Y      = '0;
        bus.i_Car_X       = '0;
        bus.i_Car_Y       = '0;
        bus.i_Car_En      = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(bus.o_Busy), 0);
        check("rst_done", int'(bus.o_Scan_Done), 0);
        check("rst_flag", int'(bus.o_Has_Collided), 0);
        check("rst_idx",  int'(bus.o_Hit_Idx), 0);
        rst_n = 1'b1;

        // Table of single scans
        for (int i = 0; i < NVEC; i++) begin
            load(vecs[i]);
            if (vecs[i].clr) pulse_clear();
            run_scan(lat);
            check($sformatf("v%0d_latency", i), lat, LAT);
            check($sformatf("v%0d_flag", i), int'(bus.o_Has_Collided), int'(vecs[i].exp_hit));
            check($sformatf("v%0d_idx", i), int'(bus.o_Hit_Idx), vecs[i].exp_idx);
        end

        // Busy window and ignored second start: exactly one done pulse at T+9
        v = vecs[12];
        load(v);
        pulse_clear();
        @(negedge clk);
        bus.i_Frame_Start = 1'b1;
        @(negedge clk);
        bus.i_Frame_Start = 1'b0;
        ndone      = 0;
        first_done = 0;
        for (int c = 1; c <= 20; c++) begin
            if (c == 1)  check("busy_first", int'(bus.o_Busy), 1);
            if (c == LAT) check("busy_last", int'(bus.o_Busy), 1);
            if (c == LAT + 1) check("busy_after", int'(bus.o_Busy), 0);
            if (bus.o_Scan_Done) begin
                ndone++;
                if (first_done == 0) first_done = c;
            end
            bus.i_Frame_Start = (c == 3);
            @(negedge clk);
        end
        bus.i_Frame_Start = 1'b0;
        check("restart_done_count", ndone, 1);
        check("restart_done_cycle", first_done, LAT);

        // Clear in the exact cycle car5 is tested: the new hit wins
        load(vecs[0]);
        pulse_clear();
        run_scan(lat);
        check("pre_clear_idx", int'(bus.o_Hit_Idx), 3);
        v    = vecs[4];
        v.en = 8'hFF;
        load(v);
        @(negedge clk);
        bus.i_Frame_Start = 1'b1;
        @(negedge clk);
        bus.i_Frame_Start = 1'b0;
        repeat (5) @(negedge clk);
        bus.i_Clear = 1'b1;
        @(negedge clk);
        bus.i_Clear = 1'b0;
        lat = 7;
        while (!bus.o_Scan_Done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("clr_hit_latency", lat, LAT);
        check("clr_hit_flag", int'(bus.o_Has_Collided), 1);
        check("clr_hit_idx", int'(bus.o_Hit_Idx), 5);

        // Reset mid-scan aborts everything; the next scan starts clean
        load(vecs[0]);
        pulse_clear();
        @(negedge clk);
        bus.i_Frame_Start = 1'b1;
        @(negedge clk);
        bus.i_Frame_Start = 1'b0;
        repeat (5) @(negedge clk);
        check("midscan_flag", int'(bus.o_Has_Collided), 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", int'(bus.o_Busy), 0);
        check("midrst_done", int'(bus.o_Scan_Done), 0);
        check("midrst_flag", int'(bus.o_Has_Collided), 0);
        check("midrst_idx",  int'(bus.o_Hit_Idx), 0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.o_Scan_Done) ndone++;
        end
        check("midrst_no_done", ndone, 0);
        load(vecs[12]);
        run_scan(lat);
        check("post_rst_latency", lat, LAT);
        check("post_rst_flag", int'(bus.o_Has_Collided), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end
endmodule
